// File: rtl/disparity_scheduler.sv
// Frame sequencer for the census disparity correlator: gates pushes, flushes the
// correlator between rows, tags in-flight pixels and buffers results for the writer.
module disparity_scheduler #(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int DISP       = 64,
   parameter int LAT        = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DW         = $clog2(DISP)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          frame_start,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          corr_reset,
   output logic          corr_bitvec_val,
   input  logic          corr_disparity_val,
   input  logic [DW-1:0] corr_disparity,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_disparity,
   output logic [9:0]    out_x,
   output logic [9:0]    out_y,
   output logic          out_pad,
   output logic          frame_done,
   output logic          busy
);

   localparam int XW = 10;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int IW = $clog2(LAT + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = DW + 2 * XW + 1;

   typedef enum logic [1:0] {
      IDLE,
      ROW_START,
      STREAM,
      ROW_DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [XW-1:0]   y_q, y_d;
   logic            rstPend_q;

   logic [LAT-1:0]  tagV_q;
   logic [XW-1:0]   tagX_q   [LAT];
   logic [XW-1:0]   tagY_q   [LAT];
   logic            tagPad_q [LAT];
   logic [IW-1:0]   inflight_q, inflight_d;

   logic [EW-1:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]   wrPtr_q, rdPtr_q;
   logic [CW-1:0]   fifoCount_q, fifoCount_d;

   logic            accept;
   logic            lastX;
   logic            lastY;
   logic            inflightZero;
   logic            credit;
   logic            emerge;
   logic            wrPad;
   logic [DW-1:0]   wrDisp;
   logic            fifoRd;
   logic [EW-1:0]   head;

   assign accept       = in_valid & in_ready;
   assign lastX        = (x_q == XW'(IMG_W - 1));
   assign lastY        = (y_q == XW'(IMG_H - 1));
   assign inflightZero = (inflight_q == '0);
   assign credit       = (int'(fifoCount_q) + int'(inflight_q) + 1) <= FIFO_DEPTH;

   // State register; rstPend_q stretches corr_reset one cycle past reset release.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         rstPend_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         rstPend_q <= 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = ROW_START;
               x_d     = '0;
               y_d     = '0;
            end
         end
         ROW_START: state_d = STREAM;
         STREAM: begin
            if (accept) begin
               if (lastX) begin
                  x_d     = '0;
                  state_d = ROW_DRAIN;
               end else begin
                  x_d = x_q + XW'(1);
               end
            end
         end
         ROW_DRAIN: begin
            // The correlator flush must wait until every tagged result is out.
            if (inflightZero) begin
               if (lastY) begin
                  y_d     = '0;
                  state_d = IDLE;
               end else begin
                  y_d     = y_q + XW'(1);
                  state_d = ROW_START;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready        = (state_q == STREAM) && credit;
      corr_bitvec_val = in_valid && in_ready;
      corr_reset      = reset || rstPend_q || (state_q == ROW_START);
      busy            = (state_q != IDLE);
      frame_done      = (state_q == ROW_DRAIN) && inflightZero && lastY;
   end

   // Fixed-latency tag pipeline mirroring the correlator's internal delay.
   always_ff @(posedge clk) begin
      if (reset) begin
         tagV_q     <= '0;
         inflight_q <= '0;
      end else begin
         tagV_q     <= {tagV_q[LAT-2:0], accept};
         inflight_q <= inflight_d;
      end
   end

   always_ff @(posedge clk) begin
      tagX_q[0]   <= x_q;
      tagY_q[0]   <= y_q;
      tagPad_q[0] <= (int'(x_q) < DISP - 1);
      for (int i = 1; i < LAT; i++) begin
         tagX_q[i]   <= tagX_q[i-1];
         tagY_q[i]   <= tagY_q[i-1];
         tagPad_q[i] <= tagPad_q[i-1];
      end
   end

   assign emerge = tagV_q[LAT-1];

   always_comb begin
      inflight_d = inflight_q + IW'(accept) - IW'(emerge);
      // A missing correlator result is recorded as padding rather than stale data.
      wrPad      = tagPad_q[LAT-1] || !corr_disparity_val;
      wrDisp     = wrPad ? '0 : corr_disparity;
   end

   assign fifoRd = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         fifoCount_q <= '0;
      end else begin
         if (emerge) wrPtr_q <= wrPtr_q + PW'(1);
         if (fifoRd) rdPtr_q <= rdPtr_q + PW'(1);
         fifoCount_q <= fifoCount_d;
      end
   end

   always_ff @(posedge clk) begin
      if (emerge) mem[wrPtr_q] <= {wrDisp, tagX_q[LAT-1], tagY_q[LAT-1], wrPad};
   end

   always_comb begin
      fifoCount_d   = fifoCount_q + CW'(emerge) - CW'(fifoRd);
      head          = mem[rdPtr_q];
      out_valid     = (fifoCount_q != '0);
      out_disparity = out_valid ? head[EW-1 -: DW] : '0;
      out_x         = out_valid ? head[2*XW : XW+1] : '0;
      out_y         = out_valid ? head[XW:1] : '0;
      out_pad       = out_valid && head[0];
   end

endmodule

// File: doc/disparity_scheduler.md
Name: disparity_scheduler

Overview:
- Sequences the 64-disparity census correlator over a frame.
- Gates bitvec pushes into the correlator and flushes its shift buffer between rows (the correlator never clears its fill state on its own).
- Tracks in-flight pixels through the fixed-latency pipeline and tags each result with pixel_x/pixel_y.
- Streams one disparity per pixel, including padded pixels, to the downstream writer over a valid/ready FIFO.

Parameters:
IMG_W, 640, pixels per row (≥ DISP)
IMG_H, 480, rows per frame
DISP, 64, correlator disparity count; first DISP-1 pixels of a row are padding
LAT, 8, cycles from accepted push to corr_disparity_val result
FIFO_DEPTH, 16, output FIFO entries (power of 2, ≥ LAT)
DW, 6, disparity width = clog2(DISP)

Ports:
clk  in  1  clock
reset  in  1  sync, active-high
frame_start  in  1  one-cycle pulse; starts a frame when IDLE
in_valid  in  1  census bitvec pair available
in_ready  out  1  scheduler accepts the pair this cycle
corr_reset  out  1  correlator reset, one-cycle pulse
corr_bitvec_val  out  1  push into correlator = in_valid & in_ready
corr_disparity_val  in  1  correlator output valid
corr_disparity  in  DW  correlator result
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accepts
out_disparity  out  DW  disparity (0 for padding)
out_x  out  10  pixel column
out_y  out  10  pixel row
out_pad  out  1  1 = padded pixel, no match computed
frame_done  out  1  one-cycle pulse after last pixel of frame enters FIFO
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; x=y=0; FIFO empty; in-flight shift register cleared. Outputs low: in_ready, corr_bitvec_val, out_valid, frame_done, busy, out_pad. corr_reset=1 during reset and for the first cycle after it.
- State ROW_START: corr_reset=1, in_ready=0 for exactly 1 cycle, then STREAM. Entered from IDLE on frame_start, and from ROW_DRAIN.
- State STREAM: in_ready = (fifo_count + inflight_count + 1 ≤ FIFO_DEPTH); credit scheme, results are never dropped.
- Accept condition: in_valid & in_ready.
  - Push a tag {x, y, pad=(x < DISP-1)} into a LAT-deep delay line.
  - x increments; at x = IMG_W-1 go to ROW_DRAIN and x wraps to 0.
- Tag emergence at cycle t+LAT: write FIFO entry.
  - Padded tag: disparity 0, pad=1; corr_disparity_val is ignored.
  - Non-pad tag: corr_disparity_val must be 1; capture corr_disparity.
  - Non-pad tag with corr_disparity_val=0: write disparity 0, pad=1 (error tolerance).
- Cycles with no emerging tag ignore corr_disparity_val. The correlator holds valid high and repeats stale results, so this rule is required.
- State ROW_DRAIN: in_ready=0 until inflight_count == 0, so the correlator reset cannot kill in-flight results. Then:
  - if y == IMG_H-1: y=0, pulse frame_done, go to IDLE;
  - else y++, go to ROW_START.
- frame_start outside IDLE is ignored.
- FIFO: simultaneous write and read at full is legal; a read frees the slot in the same cycle. Write at full cannot occur, because the credit check prevents it.
- Output valid/ready: out_* are held stable while out_valid & !out_ready.
- Reset mid-frame: FIFO and in-flight tags are discarded and the block goes IDLE; corr_reset is asserted.
- Latency: accepted pixel to out_valid = LAT+1 cycles when FIFO is empty.

Test Plan:
- IMG_W=64, IMG_H=2, in_valid=1, out_ready=1:
  - pixels x=0..62 emerge pad=1, disp=0;
  - pixel x=63 has disp = corr_disparity sampled 8 cycles after its accept;
  - corr_reset pulses once between rows;
  - frame_done fires after (1,63).
- Latency check: accept at cycle 100 with empty pipe -> out_valid at 109 with matching x/y.
- out_ready=0 held: in_ready drops once fifo_count+inflight reaches 16. Exactly 16 entries are stored, none lost. Release -> entries drain in x order, values intact.
- ROW_DRAIN: last pixel of row accepted -> in_ready low for ≥ 8 cycles. corr_reset asserts only after inflight_count=0, then row y+1 starts at x=0.
- Stale-valid: hold corr_disparity_val=1 with in_valid=0 for 20 cycles -> no FIFO writes.
- Reset asserted mid-row with 5 entries buffered -> next cycle out_valid=0, busy=0, corr_reset=1. A subsequent frame_start begins at (0,0).
